// File: rtl/rgb2ycbcr_cfg.sv
// rgb2ycbcr_cfg: mode-selectable RGB to YCbCr converter, 4-stage pipeline.
// The matrix is latched on vsync rise and carried alongside each sample.
module rgb2ycbcr_cfg #(
   parameter int R_W = 5,
   parameter int G_W = 6,
   parameter int B_W = 5
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           pre_frame_vsync,
   input  logic           pre_frame_hsync,
   input  logic           pre_frame_de,
   input  logic [R_W-1:0] img_red,
   input  logic [G_W-1:0] img_green,
   input  logic [B_W-1:0] img_blue,
   input  logic [1:0]     mode_sel,
   output logic           ycbcr_vsync,
   output logic           ycbcr_hsync,
   output logic           ycbcr_de,
   output logic [7:0]     img_y,
   output logic [7:0]     img_cb,
   output logic [7:0]     img_cr,
   output logic [1:0]     ycbcr_mode
);

   typedef logic signed [8:0]  coef_t;
   typedef logic signed [17:0] prod_t;
   typedef logic signed [19:0] sum_t;

   // Row order Y, Cb, Cr; column order R, G, B.
   localparam coef_t K601F [9] = '{
      9'sd77, 9'sd150, 9'sd29,
      -9'sd43, -9'sd85, 9'sd128,
      9'sd128, -9'sd107, -9'sd21
   };
   localparam coef_t K709F [9] = '{
      9'sd54, 9'sd183, 9'sd18,
      -9'sd29, -9'sd99, 9'sd128,
      9'sd128, -9'sd116, -9'sd12
   };
   localparam coef_t K601S [9] = '{
      9'sd66, 9'sd129, 9'sd25,
      -9'sd38, -9'sd74, 9'sd112,
      9'sd112, -9'sd94, -9'sd18
   };
   localparam sum_t OFF_C = 20'sd32896;

   logic [7:0] r8, g8, b8;
   logic [3:0] vs_sr, hs_sr, de_sr;
   logic [1:0] active_mode, m1, m2, m3, m4;
   logic       vs_rise;
   logic [7:0] px [3];
   prod_t      p_q [9];
   sum_t       s_q [3];
   sum_t       off_y;
   coef_t      k [9];
   logic [7:0] y_q, cb_q, cr_q;

   if (R_W == 8) begin : g_r_full
      assign r8 = img_red;
   end else begin : g_r_rep
      assign r8 = {img_red, img_red[R_W-1 -: 8-R_W]};
   end

   if (G_W == 8) begin : g_g_full
      assign g8 = img_green;
   end else begin : g_g_rep
      assign g8 = {img_green, img_green[G_W-1 -: 8-G_W]};
   end

   if (B_W == 8) begin : g_b_full
      assign b8 = img_blue;
   end else begin : g_b_rep
      assign b8 = {img_blue, img_blue[B_W-1 -: 8-B_W]};
   end

   // vs_sr[0] doubles as the previous-vsync register for edge detect.
   assign vs_rise = pre_frame_vsync & ~vs_sr[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vs_sr       <= '0;
         hs_sr       <= '0;
         de_sr       <= '0;
         active_mode <= '0;
      end else begin
         vs_sr <= {vs_sr[2:0], pre_frame_vsync};
         hs_sr <= {hs_sr[2:0], pre_frame_hsync};
         de_sr <= {de_sr[2:0], pre_frame_de};
         if (vs_rise)
            active_mode <= (mode_sel == 2'd3) ? 2'd0 : mode_sel;
      end
   end

   always_comb begin
      k = K601F;
      unique case (m1)
         2'd1:    k = K709F;
         2'd2:    k = K601S;
         default: k = K601F;
      endcase
   end

   assign off_y = (m2 == 2'd2) ? 20'sd4224 : 20'sd128;

   function automatic logic [7:0] clamp8(input sum_t s);
      sum_t t;
      t = s >>> 8;
      if (t < 20'sd0)
         return 8'd0;
      else if (t > 20'sd255)
         return 8'd255;
      else
         return t[7:0];
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) px[i] <= '0;
         for (int i = 0; i < 9; i++) p_q[i] <= '0;
         for (int i = 0; i < 3; i++) s_q[i] <= '0;
         m1   <= '0;
         m2   <= '0;
         m3   <= '0;
         m4   <= '0;
         y_q  <= '0;
         cb_q <= '0;
         cr_q <= '0;
      end else begin
         px[0] <= r8;
         px[1] <= g8;
         px[2] <= b8;
         m1    <= active_mode;
         for (int i = 0; i < 9; i++)
            p_q[i] <= k[i] * $signed({1'b0, px[i%3]});
         m2 <= m1;
         s_q[0] <= p_q[0] + p_q[1] + p_q[2] + off_y;
         s_q[1] <= p_q[3] + p_q[4] + p_q[5] + OFF_C;
         s_q[2] <= p_q[6] + p_q[7] + p_q[8] + OFF_C;
         m3 <= m2;
         // Blank data on the same edge its de reaches the output stage.
         y_q  <= de_sr[2] ? clamp8(s_q[0]) : 8'd0;
         cb_q <= de_sr[2] ? clamp8(s_q[1]) : 8'd0;
         cr_q <= de_sr[2] ? clamp8(s_q[2]) : 8'd0;
         m4   <= m3;
      end
   end

   assign ycbcr_vsync = vs_sr[3];
   assign ycbcr_hsync = hs_sr[3];
   assign ycbcr_de    = de_sr[3];
   assign img_y       = y_q;
   assign img_cb      = cb_q;
   assign img_cr      = cr_q;
   assign ycbcr_mode  = m4;

endmodule

// File: tb/tb_rgb2ycbcr_cfg.sv
// tb_rgb2ycbcr_cfg: three width variants driven from one 8-bit stimulus,
// checked against an arithmetic reference model every cycle.
module tb_rgb2ycbcr_cfg;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       vsync, hsync, de;
   logic [1:0] msel;
   logic [7:0] rr, gg, bb;

   logic       ov [3];
   logic       oh [3];
   logic       od [3];
   logic [7:0] oy [3];
   logic [7:0] ocb [3];
   logic [7:0] ocr [3];
   logic [1:0] om [3];

   int n_vec = 0;
   int n_err = 0;
   bit chk_on = 0;

   rgb2ycbcr_cfg #(.R_W(5), .G_W(6), .B_W(5)) dut565 (
      .clk(clk), .rst(rst),
      .pre_frame_vsync(vsync), .pre_frame_hsync(hsync),
      .pre_frame_de(de),
      .img_red(rr[7:3]), .img_green(gg[7:2]), .img_blue(bb[7:3]),
      .mode_sel(msel),
      .ycbcr_vsync(ov[0]), .ycbcr_hsync(oh[0]), .ycbcr_de(od[0]),
      .img_y(oy[0]), .img_cb(ocb[0]), .img_cr(ocr[0]),
      .ycbcr_mode(om[0])
   );

   rgb2ycbcr_cfg #(.R_W(8), .G_W(8), .B_W(8)) dut888 (
      .clk(clk), .rst(rst),
      .pre_frame_vsync(vsync), .pre_frame_hsync(hsync),
      .pre_frame_de(de),
      .img_red(rr), .img_green(gg), .img_blue(bb),
      .mode_sel(msel),
      .ycbcr_vsync(ov[1]), .ycbcr_hsync(oh[1]), .ycbcr_de(od[1]),
      .img_y(oy[1]), .img_cb(ocb[1]), .img_cr(ocr[1]),
      .ycbcr_mode(om[1])
   );

   rgb2ycbcr_cfg #(.R_W(4), .G_W(4), .B_W(4)) dut444 (
      .clk(clk), .rst(rst),
      .pre_frame_vsync(vsync), .pre_frame_hsync(hsync),
      .pre_frame_de(de),
      .img_red(rr[7:4]), .img_green(gg[7:4]), .img_blue(bb[7:4]),
      .mode_sel(msel),
      .ycbcr_vsync(ov[2]), .ycbcr_hsync(oh[2]), .ycbcr_de(od[2]),
      .img_y(oy[2]), .img_cb(ocb[2]), .img_cr(ocr[2]),
      .ycbcr_mode(om[2])
   );

   // ---------------- reference model ----------------
   int WR [3] = '{5, 8, 4};
   int WG [3] = '{6, 8, 4};
   int WB [3] = '{5, 8, 4};

   int K [3][9] = '{
      '{77, 150, 29, -43, -85, 128, 128, -107, -21},
      '{54, 183, 18, -29, -99, 128, 128, -116, -12},
      '{66, 129, 25, -38, -74, 112, 112, -94, -18}
   };
   int OF [3][3] = '{
      '{128, 32896, 32896},
      '{128, 32896, 32896},
      '{4224, 32896, 32896}
   };

   // Truncate an 8-bit sample to w bits, then widen by repeating top bits.
   function automatic int expand(input int v8, input int w);
      int c;
      c = v8 >> (8 - w);
      return (c << (8 - w)) | (c >> (2 * w - 8));
   endfunction

   function automatic void conv(input int m, input int r, input int g,
                                input int b, output logic [7:0] y,
                                output logic [7:0] cb, output logic [7:0] cr);
      int v [3];
      for (int j = 0; j < 3; j++) begin
         int s;
         s = K[m][3*j] * r + K[m][3*j+1] * g + K[m][3*j+2] * b + OF[m][j];
         s = s >>> 8;
         if (s < 0) s = 0;
         if (s > 255) s = 255;
         v[j] = s;
      end
      y  = 8'(v[0]);
      cb = 8'(v[1]);
      cr = 8'(v[2]);
   endfunction

   typedef struct packed {
      logic            vs;
      logic            hs;
      logic            de;
      logic [1:0]      md;
      logic [2:0][7:0] y;
      logic [2:0][7:0] cb;
      logic [2:0][7:0] cr;
   } exp_t;

   exp_t pipe [4];
   int   am;
   logic vprev;

   always @(posedge clk or posedge rst) begin : model
      exp_t e;
      logic [7:0] ty, tcb, tcr;
      if (rst) begin
         for (int i = 0; i < 4; i++) pipe[i] = '0;
         am    = 0;
         vprev = 1'b0;
      end else begin
         e    = '0;
         e.vs = vsync;
         e.hs = hsync;
         e.de = de;
         e.md = 2'(am);
         for (int d = 0; d < 3; d++) begin
            ty = 0; tcb = 0; tcr = 0;
            if (de)
               conv(am, expand(rr, WR[d]), expand(gg, WG[d]),
                    expand(bb, WB[d]), ty, tcb, tcr);
            e.y[d]  = ty;
            e.cb[d] = tcb;
            e.cr[d] = tcr;
         end
         pipe[3] = pipe[2];
         pipe[2] = pipe[1];
         pipe[1] = pipe[0];
         pipe[0] = e;
         if (vsync && !vprev) am = (msel == 2'd3) ? 0 : int'(msel);
         vprev = vsync;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_on) begin
         for (int d = 0; d < 3; d++) begin
            n_vec++;
            if (ov[d] !== pipe[3].vs || oh[d] !== pipe[3].hs ||
                od[d] !== pipe[3].de || om[d] !== pipe[3].md ||
                oy[d] !== pipe[3].y[d] || ocb[d] !== pipe[3].cb[d] ||
                ocr[d] !== pipe[3].cr[d]) begin
               n_err++;
               $display("FAIL pipe t=%0t dut=%0d got v%b h%b d%b m%0d y%0d cb%0d cr%0d want v%b h%b d%b m%0d y%0d cb%0d cr%0d",
                        $time, d, ov[d], oh[d], od[d], om[d], oy[d], ocb[d], ocr[d],
                        pipe[3].vs, pipe[3].hs, pipe[3].de, pipe[3].md,
                        pipe[3].y[d], pipe[3].cb[d], pipe[3].cr[d]);
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic put(input logic v, input logic h, input logic dd,
                      input logic [1:0] ms, input logic [7:0] r,
                      input logic [7:0] g, input logic [7:0] b);
      @(negedge clk);
      vsync = v; hsync = h; de = dd; msel = ms;
      rr = r; gg = g; bb = b;
   endtask

   task automatic idle(input int n, input logic [1:0] ms);
      repeat (n) put(1'b0, 1'b0, 1'b0, ms, 8'd0, 8'd0, 8'd0);
   endtask

   task automatic lit(input string nm, input int d, input int ey,
                      input int ecb, input int ecr, input int em);
      n_vec++;
      if (oy[d] !== 8'(ey) || ocb[d] !== 8'(ecb) || ocr[d] !== 8'(ecr) ||
          om[d] !== 2'(em) || od[d] !== 1'b1) begin
         n_err++;
         $display("FAIL %s dut=%0d: got y=%0d cb=%0d cr=%0d mode=%0d de=%b, want y=%0d cb=%0d cr=%0d mode=%0d de=1",
                  nm, d, oy[d], ocb[d], ocr[d], om[d], od[d], ey, ecb, ecr, em);
      end
   endtask

   task automatic chk_zero(input string nm);
      for (int d = 0; d < 3; d++) begin
         n_vec++;
         if (ov[d] !== 1'b0 || oh[d] !== 1'b0 || od[d] !== 1'b0 ||
             oy[d] !== 8'd0 || ocb[d] !== 8'd0 || ocr[d] !== 8'd0 ||
             om[d] !== 2'd0) begin
            n_err++;
            $display("FAIL %s dut=%0d: got v%b h%b d%b y%0d cb%0d cr%0d m%0d, want all 0",
                     nm, d, ov[d], oh[d], od[d], oy[d], ocb[d], ocr[d], om[d]);
         end
      end
   endtask

   task automatic pin(input string nm, input int m, input int r,
                      input int g, input int b, input int ey,
                      input int ecb, input int ecr);
      logic [7:0] y, cb, cr;
      conv(m, r, g, b, y, cb, cr);
      n_vec++;
      if (y !== 8'(ey) || cb !== 8'(ecb) || cr !== 8'(ecr)) begin
         n_err++;
         $display("FAIL pin %s: model y=%0d cb=%0d cr=%0d, want %0d %0d %0d",
                  nm, y, cb, cr, ey, ecb, ecr);
      end
   endtask

   task automatic pin_exp(input string nm, input int v8, input int w,
                          input int e);
      n_vec++;
      if (expand(v8, w) != e) begin
         n_err++;
         $display("FAIL pin %s: model %0d, want %0d", nm, expand(v8, w), e);
      end
   endtask

   // ---------------- main sequence ----------------
   logic vs_r;

   initial begin
      vsync = 0; hsync = 0; de = 0; msel = 0;
      rr = 0; gg = 0; bb = 0;

      pin("white601", 0, 255, 255, 255, 255, 128, 128);
      pin("red601", 0, 255, 0, 0, 77, 85, 255);
      pin("red709", 1, 255, 0, 0, 54, 99, 255);
      pin("white601s", 2, 255, 255, 255, 235, 128, 128);
      pin("black601s", 2, 0, 0, 0, 16, 128, 128);
      pin_exp("exp4_8", 8'h80, 4, 8'h88);
      pin_exp("exp5_31", 8'hf8, 5, 255);

      repeat (3) @(negedge clk);
      chk_zero("reset_state");
      rst    = 1'b0;
      chk_on = 1;

      put(0, 0, 1, 0, 255, 255, 255);
      idle(4, 0);
      lit("white601", 0, 255, 128, 128, 0);
      lit("white601_w8", 1, 255, 128, 128, 0);
      lit("white601_w4", 2, 255, 128, 128, 0);

      put(0, 0, 1, 0, 255, 0, 0);
      idle(4, 0);
      lit("red601", 0, 77, 85, 255, 0);

      put(1, 0, 0, 1, 0, 0, 0);
      put(0, 0, 1, 1, 255, 0, 0);
      idle(4, 1);
      lit("red709", 0, 54, 99, 255, 1);

      put(1, 0, 0, 2, 0, 0, 0);
      put(0, 0, 1, 2, 255, 255, 255);
      put(0, 0, 1, 2, 0, 0, 0);
      idle(3, 2);
      lit("white601s", 0, 235, 128, 128, 2);
      idle(1, 2);
      lit("black601s", 0, 16, 128, 128, 2);

      put(1, 0, 0, 0, 0, 0, 0);
      put(0, 0, 1, 0, 8'h80, 8'h80, 8'h80);
      idle(4, 0);
      lit("exp4_88", 2, 136, 128, 128, 0);

      put(0, 0, 1, 2, 255, 0, 0);
      idle(4, 2);
      lit("midframe_sel", 0, 77, 85, 255, 0);

      put(1, 0, 1, 2, 255, 0, 0);
      put(1, 0, 1, 2, 255, 0, 0);
      idle(3, 2);
      lit("edge_sample", 0, 77, 85, 255, 0);
      idle(1, 2);
      lit("post_edge", 0, 82, 90, 240, 2);

      vs_r = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 59) == 0) vs_r = ~vs_r;
         put(vs_r, 1'($urandom), ($urandom_range(0, 3) != 0),
             2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
             8'($urandom));
         if (i == 1500) begin
            #2 rst = 1'b1;
            #1 chk_zero("async_rst");
            @(negedge clk);
            rst = 1'b0;
         end
      end

      idle(6, 0);
      chk_on = 0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rgb2ycbcr_cfg.md
# rgb2ycbcr_cfg

Parametrised, mode-selectable RGB-to-YCbCr converter for the camera video path, sitting between the sensor/RGB stream and downstream Y-based processing (binarization, edge detection). Accepts per-channel RGB of configurable width. Expands each channel to 8 bits and applies one of three fixed-point colour matrices, selected per frame. Rounds, clamps to 0..255, and delays sync/enable signals so they stay aligned with the data.

## Interface
Parameters:
- R_W, 5, red input width (4..8)
- G_W, 6, green input width (4..8)
- B_W, 5, blue input width (4..8)

Ports:
- clk  in  1  pixel clock; the single clock of the block
- rst  in  1  asynchronous, active-high reset
- pre_frame_vsync  in  1  frame sync
- pre_frame_hsync  in  1  line sync
- pre_frame_de  in  1  pixel data enable
- img_red  in  R_W  red sample
- img_green  in  G_W  green sample
- img_blue  in  B_W  blue sample
- mode_sel  in  2  requested matrix: 0 BT.601 full, 1 BT.709 full, 2 BT.601 studio, 3 reserved (treated as 0)
- ycbcr_vsync  out  1  vsync delayed 4 cycles
- ycbcr_hsync  out  1  hsync delayed 4 cycles
- ycbcr_de  out  1  de delayed 4 cycles
- img_y  out  8  luma
- img_cb  out  8  blue chroma
- img_cr  out  8  red chroma
- ycbcr_mode  out  2  matrix used for the sample currently on img_y/cb/cr

## Operation
- Width expansion to 8 bits by MSB replication: c8 = {c, c[W-1 -: 8-W]}. A channel with W=8 passes through unchanged.
- Coefficients use 8 fractional bits. Each output is sum = kR*R + kG*G + kB*B + O, then result = clamp((sum >>> 8), 0, 255).
- Intermediate arithmetic is signed, at least 18 bits wide, with no overflow.
- Mode 0, BT.601 full range:
  - Y (77,150,29), O=128
  - Cb (-43,-85,128), O=32896
  - Cr (128,-107,-21), O=32896
- Mode 1, BT.709 full range:
  - Y (54,183,18), O=128
  - Cb (-29,-99,128), O=32896
  - Cr (128,-116,-12), O=32896
- Mode 2, BT.601 studio range:
  - Y (66,129,25), O=4224
  - Cb (-38,-74,112), O=32896
  - Cr (112,-94,-18), O=32896
- Mode latching:
  - active_mode is a register, reset value 0.
  - It loads mode_sel on any clock edge where pre_frame_vsync=1 and its registered previous value was 0 (vsync rising edge).
  - mode_sel is ignored at all other times. A mid-frame change of mode_sel has no effect until the next vsync rise.
- Stage-1 samples use the active_mode value before that edge. active_mode travels down the pipeline with each sample, so a frame never mixes matrices and ycbcr_mode always matches the data.
- img_y/img_cb/img_cr are forced to 0 whenever ycbcr_de=0.

## Timing
- Pipeline stages:
  - S1: expand and register RGB888 plus mode
  - S2: nine products
  - S3: add offsets
  - S4: shift and clamp
- Latency is 4 cycles: an input at edge N appears on the outputs after edge N+4. Throughput is one pixel per clock; there is no stall or backpressure.
- Sync and enable signals pass through 4-stage shift registers, identical latency to the data.
- Reset (asynchronous, any time, including mid-frame) clears all pipeline, sync and mode registers immediately.
  - All outputs read 0 during reset; ycbcr_mode reads 0.
- After reset release, outputs stay 0 for 4 cycles until valid data propagates.

## Test plan
- Mode 0, RGB565 white (31,63,31) with de=1 -> 4 cycles later Y=255, Cb=128, Cr=128, ycbcr_mode=0.
- Mode 0, pure red (31,0,0) -> Y=77, Cb=85, Cr=255 (clamped from 256). Mode 1 with the same pixel -> Y=54, Cb=99, Cr=255.
- Mode 2, white -> Y=235, Cb=128, Cr=128; black (0,0,0) -> Y=16, Cb=128, Cr=128.
- mode_sel changes 0->2 mid-frame:
  - Remaining pixels of that frame still use mode 0.
  - After the next vsync rise, pixels use mode 2 and ycbcr_mode switches exactly on the first post-edge sample.
- de toggling 1,0,1 with constant non-black input -> outputs nonzero, 0, nonzero, aligned 4 cycles later with ycbcr_de. hsync/vsync pulses are delayed exactly 4 cycles.
- Assert rst mid-frame with nonzero data in flight -> all outputs 0 immediately and active_mode=0. After release, first valid output appears 4 cycles after the first input.
- Parameter sweep R_W=G_W=B_W=8 and R_W=G_W=B_W=4 -> full-scale input gives Y=255 in mode 0. For 4-bit, input value 8 expands to 0x88.
